// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Producer-side tracker for the 5-stage core. It follows the destination
//   register and load status of the instructions in EX, MEM and WB. It then
//   raises the stall, bubble and flush controls for the hazards that the
//   ID-stage forwarding unit cannot resolve, and it freezes the pipeline while
//   data memory is busy.
//
// Ports
//   clk, reset        core clock, synchronous active-high reset
//   id_valid          ID stage holds a real instruction
//   id_rs1/id_rs2     ID source registers, qualified by id_use_rs1/id_use_rs2
//   id_branch         ID instruction is a conditional branch resolved in ID
//   id_rd             ID destination register
//   id_reg_write      ID instruction writes id_rd
//   id_mem_read       ID instruction is a load
//   branch_taken      branch in ID resolved taken this cycle
//   mem_busy          data memory not ready; freezes the pipeline
//   addr_write_mem    rd of the MEM instruction, 0 if it does not write
//   addr_write_wb     rd of the WB instruction, 0 if it does not write
//   stall_pc          hold PC
//   stall_ifid        hold IF/ID
//   bubble_idex       load a NOP into ID/EX
//   flush_ifid        clear IF/ID
//   freeze            hold all pipeline registers
//   stall_cycles      saturating count of cycles with stall_pc asserted
module hazard_stall_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_branch,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic [REG_AW-1:0] addr_write_mem,
  output logic [REG_AW-1:0] addr_write_wb,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic              freeze,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic              ex_we, ex_ld, mem_we, mem_ld, wb_we;
  logic              ex_match, mem_match, hazard;

  // A source operand depends on a stage only if that operand is really read,
  // the operand is not x0, and the stage really writes that register.
  function automatic logic src_match(input logic              use_bit,
                                     input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] rd,
                                     input logic              we);
    return use_bit && (src != '0) && (src == rd) && we;
  endfunction

  // ID-stage hazard detection against the tracked producers
  always_comb begin
    ex_match  = src_match(id_use_rs1, id_rs1, ex_rd, ex_we) ||
                src_match(id_use_rs2, id_rs2, ex_rd, ex_we);
    mem_match = src_match(id_use_rs1, id_rs1, mem_rd, mem_we) ||
                src_match(id_use_rs2, id_rs2, mem_rd, mem_we);
    // Non-branches forward from EX except when EX holds a load. A branch
    // compares in ID, so it cannot use any EX result. It also cannot use a
    // load that is still in MEM. A load directly ahead of a dependent branch
    // therefore stalls twice: first on EX, then on MEM.
    hazard = id_valid && ((!id_branch && ex_match && ex_ld) ||
                          ( id_branch && ex_match) ||
                          ( id_branch && mem_match && mem_ld));
  end

  // Priority is freeze, then hazard, then flush. A taken branch that is
  // suppressed here is re-presented upstream once the branch resolves.
  assign freeze         = mem_busy;
  assign stall_pc       = mem_busy || hazard;
  assign stall_ifid     = mem_busy || hazard;
  assign bubble_idex    = hazard && !mem_busy;
  assign flush_ifid     = branch_taken && !hazard && !mem_busy;
  assign addr_write_mem = mem_we ? mem_rd : '0;
  assign addr_write_wb  = wb_we  ? wb_rd  : '0;

  // EX -> MEM -> WB tracker advance, plus the stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd        <= '0;
      ex_we        <= 1'b0;
      ex_ld        <= 1'b0;
      mem_rd       <= '0;
      mem_we       <= 1'b0;
      mem_ld       <= 1'b0;
      wb_rd        <= '0;
      wb_we        <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (!mem_busy) begin
        wb_rd  <= mem_rd;
        wb_we  <= mem_we;
        mem_rd <= ex_rd;
        mem_we <= ex_we;
        mem_ld <= ex_ld;
        if (hazard || !id_valid) begin
          ex_rd <= '0;
          ex_we <= 1'b0;
          ex_ld <= 1'b0;
        end else begin
          ex_rd <= id_rd;
          ex_we <= id_reg_write;
          ex_ld <= id_mem_read;
        end
      end
      if (stall_pc && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  localparam int AW = 5;
  localparam int CW = 3;   // narrow counter so that saturation is reached
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_use_rs1, id_use_rs2, id_branch;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_reg_write, id_mem_read, branch_taken, mem_busy;
  logic [AW-1:0] addr_write_mem, addr_write_wb;
  logic          stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    string         tag;
    logic          stall, bub, flush, frz;
    logic [AW-1:0] awm, awb;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t sb[$];

  hazard_stall_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_branch(id_branch), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .addr_write_mem(addr_write_mem),
    .addr_write_wb(addr_write_wb), .stall_pc(stall_pc),
    .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .freeze(freeze), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_branch = 0; id_rd = 0; id_reg_write = 0; id_mem_read = 0;
    branch_taken = 0; mem_busy = 0;
  endtask

  task automatic producer(input logic [AW-1:0] rd, input logic ld);
    idle();
    id_valid = 1; id_rd = rd; id_reg_write = 1; id_mem_read = ld;
  endtask

  task automatic branch(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic u1, input logic u2);
    idle();
    id_valid = 1; id_branch = 1; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2;
  endtask

  // Inputs are already applied just after a rising edge. The expectation is
  // queued here, then popped and compared mid-cycle, and the task then
  // advances one clock.
  task automatic cyc(input string tag, input logic st, input logic bub,
                     input logic fl, input logic fz,
                     input logic [AW-1:0] awm, input logic [AW-1:0] awb);
    exp_t e, g;
    e.tag = tag; e.stall = st; e.bub = bub; e.flush = fl; e.frz = fz;
    e.awm = awm; e.awb = awb; e.cnt = CW'(exp_cnt);
    sb.push_back(e);
    if (st && exp_cnt < CMAX) exp_cnt++;
    #3;
    g = sb.pop_front();
    chk(g.tag, "stall_pc",       32'(stall_pc),       32'(g.stall));
    chk(g.tag, "stall_ifid",     32'(stall_ifid),     32'(g.stall));
    chk(g.tag, "bubble_idex",    32'(bubble_idex),    32'(g.bub));
    chk(g.tag, "flush_ifid",     32'(flush_ifid),     32'(g.flush));
    chk(g.tag, "freeze",         32'(freeze),         32'(g.frz));
    chk(g.tag, "addr_write_mem", 32'(addr_write_mem), 32'(g.awm));
    chk(g.tag, "addr_write_wb",  32'(addr_write_wb),  32'(g.awb));
    chk(g.tag, "stall_cycles",   32'(stall_cycles),   32'(g.cnt));
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    cyc("reset", 0, 0, 0, 0, 0, 0);

    // ALU producer then dependent branch: one stall, then forward from MEM
    producer(5, 0);           cyc("alu_prod",   0, 0, 0, 0, 0, 0);
    branch(5, 0, 1, 0);       cyc("alu_br_st",  1, 1, 0, 0, 0, 0);
                              cyc("alu_br_go",  0, 0, 0, 0, 5, 0);
    idle();                   cyc("alu_drain",  0, 0, 0, 0, 0, 5);

    // Load producer then dependent branch on rs2: two stalls
    producer(7, 1);           cyc("ld_prod",    0, 0, 0, 0, 0, 0);
    branch(0, 7, 0, 1);       cyc("ld_br_st1",  1, 1, 0, 0, 0, 0);
                              cyc("ld_br_st2",  1, 1, 0, 0, 7, 0);
                              cyc("ld_br_go",   0, 0, 0, 0, 0, 7);
    idle();                   cyc("ld_drain",   0, 0, 0, 0, 0, 0);

    // Load-use on a non-branch, then x0 never matches
    producer(3, 1);           cyc("lu_prod",    0, 0, 0, 0, 0, 0);
    producer(4, 0); id_use_rs1 = 1; id_rs1 = 3;
                              cyc("lu_st",      1, 1, 0, 0, 0, 0);
                              cyc("lu_go",      0, 0, 0, 0, 3, 0);
    producer(0, 1);           cyc("x0_load",    0, 0, 0, 0, 0, 3);
    producer(6, 0); id_use_rs1 = 1; id_use_rs2 = 1;
                              cyc("x0_use",     0, 0, 0, 0, 4, 0);
    idle();                   cyc("x0_drain1",  0, 0, 0, 0, 0, 4);
                              cyc("x0_drain2",  0, 0, 0, 0, 6, 0);
                              cyc("x0_drain3",  0, 0, 0, 0, 0, 6);

    // Taken branch without and with a hazard
    branch(1, 0, 1, 0); branch_taken = 1;
                              cyc("tk_flush",   0, 0, 1, 0, 0, 0);
    idle();                   cyc("tk_after",   0, 0, 0, 0, 0, 0);
    producer(8, 0);           cyc("tk_prod",    0, 0, 0, 0, 0, 0);
    branch(8, 0, 1, 0); branch_taken = 1;
                              cyc("tk_haz",     1, 1, 0, 0, 0, 0);
                              cyc("tk_reflush", 0, 0, 1, 0, 8, 0);
    idle();                   cyc("tk_drain",   0, 0, 0, 0, 0, 8);

    // Freeze with EX=x9 and MEM=x10; the tracker must hold. The counter
    // reaches saturation here.
    producer(10, 0);          cyc("fz_prod10",  0, 0, 0, 0, 0, 0);
    producer(9, 0);           cyc("fz_prod9",   0, 0, 0, 0, 0, 0);
    branch(9, 0, 1, 0); mem_busy = 1;
                              cyc("fz_c1",      1, 0, 0, 1, 10, 0);
    branch_taken = 1;         cyc("fz_c2",      1, 0, 0, 1, 10, 0);
    branch_taken = 0;         cyc("fz_c3",      1, 0, 0, 1, 10, 0);
    mem_busy = 0;             cyc("fz_haz",     1, 1, 0, 0, 10, 0);
                              cyc("fz_go",      0, 0, 0, 0, 9, 10);
    idle();                   cyc("fz_drain",   0, 0, 0, 0, 0, 9);

    // Reset during the first cycle of a load-branch stall
    producer(7, 1);           cyc("rs_prod",    0, 0, 0, 0, 0, 0);
    branch(0, 7, 0, 1); reset = 1;
                              cyc("rs_st1",     1, 1, 0, 0, 0, 0);
    exp_cnt = 0;
    reset = 0;                cyc("rs_after1",  0, 0, 0, 0, 0, 0);
                              cyc("rs_after2",  0, 0, 0, 0, 0, 0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
